// File: rtl/alu_pipe_if.sv
// Bus between the register-file read stage, alu_pipe and write-back.
// master: operation source (drives in_valid/opcode/a/b, sees in_ready and results)
// slave : alu_pipe (accepts operations, drives result/flags/out_valid/op_err/in_ready)
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;
    logic             out_valid;
    logic             op_err;

    modport master (
        output in_valid, opcode, a, b,
        input  in_ready, result, flags, out_valid, op_err
    );

    modport slave (
        input  in_valid, opcode, a, b,
        output in_ready, result, flags, out_valid, op_err
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with stored status flags and an iterative shift-add multiply.
// Ports: clk, rst_n (async active-low), bus (alu_pipe_if.slave):
//   in_valid/in_ready handshake, opcode/a/b operands, result/flags registered
//   outputs, out_valid and op_err one-cycle strobes.
// flags: [0] N, [1] L, [2] F (overflow), [3] C, [4] Z.
module alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int unsigned CW = SHW + 1;
    localparam int unsigned FN = 0;
    localparam int unsigned FL = 1;
    localparam int unsigned FF = 2;
    localparam int unsigned FC = 3;
    localparam int unsigned FZ = 4;

    localparam logic [3:0] OP_AND   = 4'h1;
    localparam logic [3:0] OP_OR    = 4'h2;
    localparam logic [3:0] OP_XOR   = 4'h3;
    localparam logic [3:0] OP_ADDCU = 4'h4;
    localparam logic [3:0] OP_ADD   = 4'h5;
    localparam logic [3:0] OP_ADDU  = 4'h6;
    localparam logic [3:0] OP_ADDC  = 4'h7;
    localparam logic [3:0] OP_SUB   = 4'h9;
    localparam logic [3:0] OP_CMP   = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hE;
    localparam logic [3:0] CL_REG   = 4'h0;
    localparam logic [3:0] CL_SHF   = 4'h8;
    localparam logic [3:0] SH_LSH   = 4'h4;
    localparam logic [3:0] SH_ALSH  = 4'h6;
    localparam logic [3:0] SH_RSH   = 4'hC;
    localparam logic [3:0] SH_ARSH  = 4'hE;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   result_q, result_nx;
    logic [4:0]         flags_q, flags_nx;
    logic               out_valid_q, out_valid_nx;
    logic               op_err_q, op_err_nx;
    logic               in_ready_q, in_ready_nx;
    logic [2*WIDTH-1:0] mcand_q, mcand_nx;
    logic [2*WIDTH-1:0] acc_q, acc_nx, acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_nx;
    logic [CW-1:0]      cnt_q, cnt_nx;

    logic [3:0]         cls, ext, op;
    logic [7:0]         imm8;
    logic [WIDTH-1:0]   opb, alu_res;
    logic [4:0]         alu_flg;
    logic               is_shf, is_mul, known, cin, ult, slt, sh_over;
    logic [WIDTH:0]     sum, dif;
    logic [SHW-1:0]     sh_amt;

    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = out_valid_q;
    assign bus.op_err    = op_err_q;
    assign bus.in_ready  = in_ready_q;

    function automatic logic is_alu_code(input logic [3:0] c);
        case (c)
            OP_AND, OP_OR, OP_XOR, OP_ADDCU, OP_ADD,
            OP_ADDU, OP_ADDC, OP_SUB, OP_CMP: is_alu_code = 1'b1;
            default:                          is_alu_code = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_imm(input logic [3:0] c);
        return (c == OP_ADD) || (c == OP_ADDC) || (c == OP_SUB) || (c == OP_CMP);
    endfunction

    // Decode register/shift/immediate forms and evaluate the single-cycle ops.
    always_comb begin
        cls     = bus.opcode[7:4];
        ext     = bus.opcode[3:0];
        imm8    = {ext, bus.b[3:0]};
        op      = ext;
        opb     = bus.b;
        is_shf  = 1'b0;
        is_mul  = 1'b0;
        known   = 1'b0;
        alu_res = '0;
        alu_flg = '0;
        if (cls == CL_REG) begin
            is_mul = (ext == OP_MUL);
            known  = is_alu_code(ext) || is_mul;
        end else if (cls == CL_SHF) begin
            is_shf = 1'b1;
            known  = (ext == SH_LSH) || (ext == SH_ALSH) || (ext == SH_RSH) || (ext == SH_ARSH);
        end else begin
            // Immediate form: class selects the op, imm8 replaces b.
            op    = cls;
            known = is_alu_code(cls);
            opb   = is_signed_imm(cls) ? {{(WIDTH-8){imm8[7]}}, imm8}
                                       : {{(WIDTH-8){1'b0}}, imm8};
        end

        cin     = ((op == OP_ADDC) || (op == OP_ADDCU)) & flags_q[FC];
        sum     = {1'b0, bus.a} + {1'b0, opb} + (WIDTH+1)'(cin);
        dif     = {1'b0, bus.a} - {1'b0, opb};
        ult     = dif[WIDTH];
        slt     = $signed(bus.a) < $signed(opb);
        sh_amt  = bus.b[SHW-1:0];
        sh_over = |(bus.b >> SHW);

        if (is_shf) begin
            case (ext)
                SH_LSH, SH_ALSH: alu_res = sh_over ? '0 : (bus.a << sh_amt);
                SH_RSH:          alu_res = sh_over ? '0 : (bus.a >> sh_amt);
                SH_ARSH:         alu_res = sh_over ? {WIDTH{bus.a[WIDTH-1]}}
                                                   : WIDTH'($signed(bus.a) >>> sh_amt);
                default:         alu_res = '0;
            endcase
            alu_flg[FN] = alu_res[WIDTH-1];
        end else begin
            case (op)
                OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
                    alu_res     = sum[WIDTH-1:0];
                    alu_flg[FC] = sum[WIDTH];
                    alu_flg[FN] = sum[WIDTH-1];
                    if ((op == OP_ADD) || (op == OP_ADDC))
                        alu_flg[FF] = (bus.a[WIDTH-1] == opb[WIDTH-1]) &&
                                      (sum[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_SUB: begin
                    alu_res     = dif[WIDTH-1:0];
                    alu_flg[FC] = ult;
                    alu_flg[FL] = ult;
                    alu_flg[FN] = slt;
                    alu_flg[FF] = (bus.a[WIDTH-1] != opb[WIDTH-1]) &&
                                  (dif[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_CMP: begin
                    alu_flg[FL] = ult;
                    alu_flg[FN] = slt;
                end
                OP_AND: begin
                    alu_res     = bus.a & opb;
                    alu_flg[FN] = alu_res[WIDTH-1];
                end
                OP_OR: begin
                    alu_res     = bus.a | opb;
                    alu_flg[FN] = alu_res[WIDTH-1];
                end
                OP_XOR: begin
                    alu_res     = bus.a ^ opb;
                    alu_flg[FN] = alu_res[WIDTH-1];
                end
                default: ;
            endcase
        end
        // CMP reports equality in Z; everything else reports a zero result.
        alu_flg[FZ] = (!is_shf && (op == OP_CMP)) ? (bus.a == opb) : (alu_res == '0);
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state and registered-output logic.
    always_comb begin
        state_nx     = state;
        result_nx    = result_q;
        flags_nx     = flags_q;
        out_valid_nx = 1'b0;
        op_err_nx    = 1'b0;
        mcand_nx     = mcand_q;
        mplier_nx    = mplier_q;
        acc_nx       = acc_q;
        cnt_nx       = cnt_q;
        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    if (!known) begin
                        result_nx    = '0;
                        op_err_nx    = 1'b1;
                        out_valid_nx = 1'b1;
                    end else if (is_mul) begin
                        mcand_nx  = {{WIDTH{1'b0}}, bus.a};
                        mplier_nx = bus.b;
                        acc_nx    = '0;
                        cnt_nx    = CW'(WIDTH);
                        state_nx  = MUL_BUSY;
                    end else begin
                        result_nx    = alu_res;
                        flags_nx     = alu_flg;
                        out_valid_nx = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                // One partial product per cycle; the last one retires the result.
                acc_nx    = acc_step;
                mcand_nx  = mcand_q << 1;
                mplier_nx = mplier_q >> 1;
                cnt_nx    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_nx    = acc_step[WIDTH-1:0];
                    flags_nx     = '0;
                    flags_nx[FN] = acc_step[WIDTH-1];
                    flags_nx[FC] = |acc_step[2*WIDTH-1:WIDTH];
                    flags_nx[FZ] = (acc_step[WIDTH-1:0] == '0);
                    out_valid_nx = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        in_ready_nx = (state_nx == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            op_err_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state       <= state_nx;
            result_q    <= result_nx;
            flags_q     <= flags_nx;
            out_valid_q <= out_valid_nx;
            op_err_q    <= op_err_nx;
            in_ready_q  <= in_ready_nx;
            mcand_q     <= mcand_nx;
            mplier_q    <= mplier_nx;
            acc_q       <= acc_nx;
            cnt_q       <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed cases with fixed expectations,
// randomized ops checked against a behavioural model, and a 32-bit instance.
module tb_alu_pipe;
    localparam int unsigned W = 16;
    localparam logic [W-1:0] W_B = W'(W);
    localparam logic [3:0] REGC [10] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hE};
    localparam logic [3:0] SHC  [4]  = '{4'h4, 4'h6, 4'hC, 4'hE};

    typedef struct packed {
        logic [W-1:0] r;
        logic [4:0]   f;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W))  bus ();
    alu_pipe_if #(.WIDTH(32)) bus32 ();
    alu_pipe #(.WIDTH(W))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    exp_t       sb[$];
    logic [4:0] mf;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: result, flags and error flag from the opcode rules.
    function automatic exp_t model(input logic [7:0] opc, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [4:0] fin);
        exp_t e;
        logic [3:0] cls, op;
        logic [7:0] imm;
        logic [W-1:0] bo;
        logic [W:0] s;
        logic [2*W-1:0] p;
        logic n, l, fv, c, z;
        cls = opc[7:4];
        imm = {opc[3:0], b[3:0]};
        e.r = '0; e.f = fin; e.err = 1'b0;
        n = 0; l = 0; fv = 0; c = 0;
        if (cls == 4'h8) begin
            case (opc[3:0])
                4'h4, 4'h6: e.r = (b >= W_B) ? '0 : (a << b);
                4'hC:       e.r = (b >= W_B) ? '0 : (a >> b);
                4'hE:       e.r = (b >= W_B) ? {W{a[W-1]}} : W'($signed(a) >>> b);
                default: begin e.err = 1'b1; return e; end
            endcase
            e.f = {(e.r == '0), 3'b000, e.r[W-1]};
            return e;
        end
        if (cls == 4'h0) begin
            op = opc[3:0];
            bo = b;
        end else begin
            op = cls;
            if (cls == 4'hE) begin e.err = 1'b1; return e; end
            bo = (cls == 4'h5 || cls == 4'h7 || cls == 4'h9 || cls == 4'hB)
                 ? {{(W-8){imm[7]}}, imm} : {{(W-8){1'b0}}, imm};
        end
        case (op)
            4'h4, 4'h5, 4'h6, 4'h7: begin
                s = {1'b0, a} + {1'b0, bo} + (W+1)'((op == 4'h4 || op == 4'h7) ? fin[3] : 1'b0);
                e.r = s[W-1:0]; c = s[W]; n = e.r[W-1];
                if (op == 4'h5 || op == 4'h7) fv = (a[W-1] == bo[W-1]) && (e.r[W-1] != a[W-1]);
            end
            4'h9: begin
                e.r = a - bo; c = (a < bo); l = (a < bo); n = ($signed(a) < $signed(bo));
                fv = (a[W-1] != bo[W-1]) && (e.r[W-1] != a[W-1]);
            end
            4'hB: begin l = (a < bo); n = ($signed(a) < $signed(bo)); end
            4'h1: begin e.r = a & bo; n = e.r[W-1]; end
            4'h2: begin e.r = a | bo; n = e.r[W-1]; end
            4'h3: begin e.r = a ^ bo; n = e.r[W-1]; end
            4'hE: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.r = p[W-1:0]; c = (p[2*W-1:W] != '0); n = e.r[W-1];
            end
            default: begin e.err = 1'b1; return e; end
        endcase
        z = (op == 4'hB) ? (a == bo) : (e.r == '0);
        e.f = {z, c, fv, l, n};
        return e;
    endfunction

    // Present an op, wait for acceptance, push the expectation; returns one
    // cycle later with in_valid dropped.
    task automatic issue(input logic [7:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit directed, input logic [W-1:0] er, input logic [4:0] ef,
                         input bit eerr);
        exp_t m;
        int guard;
        bus.in_valid = 1'b1; bus.opcode = opc; bus.a = a; bus.b = b;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin @(negedge clk); guard++; end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        m = model(opc, a, b, mf);
        if (!m.err) mf = m.f;
        if (directed) sb.push_back('{r: er, f: ef, err: eerr});
        else          sb.push_back(m);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic dir(input logic [7:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [4:0] ef);
        issue(opc, a, b, 1'b1, er, ef, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: every out_valid pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("result", 64'(bus.result), 64'(e.r));
                chk("flags",  64'(bus.flags),  64'(e.f));
                chk("op_err", 64'(bus.op_err), 64'(e.err));
            end
        end else if (rst_n && bus.op_err) begin
            chk("op_err_without_out_valid", 64'd1, 64'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int busy;
        logic [7:0] opc;
        logic [W-1:0] ra, rb;
        logic ov_seen;
        bus.in_valid = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0;
        bus32.in_valid = 1'b0; bus32.opcode = '0; bus32.a = '0; bus32.b = '0;
        mf = '0;
        repeat (3) @(negedge clk);
        chk("rst_result",    64'(bus.result),    64'd0);
        chk("rst_flags",     64'(bus.flags),     64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_op_err",    64'(bus.op_err),    64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        dir(8'h06, 16'hFFFF, 16'h0001, 16'h0000, 5'h18);  // ADDU carry out
        dir(8'h04, 16'h0000, 16'h0000, 16'h0001, 5'h00);  // ADDCU consumes C
        dir(8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'h05);  // ADD overflow
        dir(8'h9F, 16'h0005, 16'h000F, 16'h0006, 5'h0A);  // SUB imm -1
        dir(8'h0B, 16'hFFFF, 16'h0001, 16'h0000, 5'h01);  // CMP signed less
        dir(8'h0B, 16'h0003, 16'h0003, 16'h0000, 5'h10);  // CMP equal
        dir(8'h8E, 16'h8000, 16'h0004, 16'hF800, 5'h01);  // ARSH
        dir(8'h8E, 16'h8000, 16'h0010, 16'hFFFF, 5'h01);  // ARSH overrange
        dir(8'h8C, 16'h8000, 16'h0010, 16'h0000, 5'h10);  // RSH overrange
        dir(8'h84, 16'h0001, 16'h000F, 16'h8000, 5'h01);  // LSH max
        dir(8'h0E, 16'h0100, 16'h0100, 16'h0000, 5'h18);  // MUL high half set

        // Hold an ADD while the multiplier is busy; it must wait.
        bus.in_valid = 1'b1; bus.opcode = 8'h05; bus.a = 16'h0001; bus.b = 16'h0002;
        busy = 0;
        while (!bus.in_ready && busy < 40) begin busy++; @(negedge clk); end
        chk("mul_busy_cycles", 64'(busy), 64'd16);
        chk("mul_out_valid_at_release", 64'(bus.out_valid), 64'd1);
        dir(8'h05, 16'h0001, 16'h0002, 16'h0003, 5'h00);
        dir(8'h0B, 16'h0003, 16'h0003, 16'h0000, 5'h10);
        issue(8'h0F, 16'h1234, 16'h0005, 1'b1, 16'h0000, 5'h10, 1'b1);  // undefined
        drain();

        // Reset in the middle of a multiply.
        bus.in_valid = 1'b1; bus.opcode = 8'h0E; bus.a = 16'h0100; bus.b = 16'h0100;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        mf = '0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midmul_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midmul_flags",    64'(bus.flags),    64'd0);
        chk("midmul_result",   64'(bus.result),   64'd0);
        ov_seen = 1'b0;
        repeat (W + 4) begin
            ov_seen = ov_seen | bus.out_valid;
            @(negedge clk);
        end
        chk("midmul_no_out_valid", 64'(ov_seen), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            ra = pick();
            rb = pick();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: opc = {4'h0, REGC[$urandom_range(0, 9)]};
                4, 5: begin
                    opc = {4'h8, SHC[$urandom_range(0, 3)]};
                    if ($urandom_range(0, 1) == 1) rb = W'($urandom_range(0, 2 * W));
                end
                6, 7:    opc = {REGC[$urandom_range(0, 8)], 4'($urandom)};
                default: opc = 8'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(opc, ra, rb, 1'b0, '0, '0, 1'b0);
        end
        drain();

        // WIDTH = 32 instance: carry chain across ADDU then ADDCU.
        bus32.in_valid = 1'b1; bus32.opcode = 8'h06; bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h1;
        @(negedge clk);
        chk("w32_addu_valid",  64'(bus32.out_valid), 64'd1);
        chk("w32_addu_result", 64'(bus32.result),    64'd0);
        chk("w32_addu_flags",  64'(bus32.flags),     64'h18);
        bus32.opcode = 8'h04; bus32.a = '0; bus32.b = '0;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        chk("w32_addcu_valid",  64'(bus32.out_valid), 64'd1);
        chk("w32_addcu_result", 64'(bus32.result),    64'd1);
        chk("w32_addcu_flags",  64'(bus32.flags),     64'h00);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the team's 16-bit combinational ALU. It executes the same register, shift and immediate opcode set at `WIDTH` bits and adds an iterative multiply. It holds the processor status flags in an internal register, so `ADDC`/`ADDCU` consume a real stored carry. It sits between the register-file read stage and write-back, with a valid/ready input handshake and a one-cycle result strobe.

## Interface
- `WIDTH`, 16, datapath width; must be ≥ 8 and a power of two.
- `SHW`, `$clog2(WIDTH)`, number of shift-amount bits taken from B.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and opcode are valid.
- `in_ready`  out  1  block can accept an operation this cycle.
- `opcode`  in  8  `[7:4]` class, `[3:0]` extension or imm-high nibble.
- `a`, `b`  in  WIDTH  operands; for immediate forms, `b[3:0]` is the imm-low nibble.
- `result`  out  WIDTH  registered result.
- `flags`  out  5  status register: [0] N, [1] L, [2] F (overflow), [3] C, [4] Z.
- `out_valid`  out  1  one-cycle pulse; `result` and `flags` have just updated.
- `op_err`  out  1  one-cycle pulse; an undefined opcode was accepted.

## Operation
- An operation is accepted when `in_valid & in_ready` are both high at a clock edge.
- **Class 0000 (register ops).** Extension codes:
  - ADD 0101, ADDU 0110, ADDC 0111, ADDCU 0100
  - SUB 1001, CMP 1011
  - AND 0001, OR 0010, XOR 0011
  - MUL 1110 (new)
- **Class 1000 (shifts).** Extension codes: LSH/ALSH 0100/0110, RSH 1100, ARSH 1110.
  - Shift amount is `b[SHW-1:0]`.
  - If any higher bit of `b` is set: result is 0 (LSH, ALSH, RSH), or WIDTH copies of `a[MSB]` (ARSH).
- **Immediate forms.** Any other class equal to one of the register-op extension codes (except MUL) is that op with imm8 = {`opcode[3:0]`, `b[3:0]`}.
  - Sign-extended to WIDTH for ADD, ADDC, SUB, CMP.
  - Zero-extended for ADDU, ADDCU, AND, OR, XOR.
- **Flag rules.** Z = (result == 0) for every op except CMP.
  - ADD/ADDU/ADDC/ADDCU: C = carry-out of the WIDTH+1-bit sum. ADDC/ADDCU add the stored C.
  - ADD/ADDC only: F = signed overflow (operands share a sign that differs from the result sign).
  - SUB: C = borrow (unsigned a < b). F = (a and b signs differ) and (result sign ≠ a sign).
  - CMP: result = 0; Z = (a == b); L = unsigned a < b; N = signed a < b; C = F = 0.
  - SUB: L and N are computed as for CMP.
  - AND/OR/XOR/shifts/MUL: N = result MSB; L = F = 0.
  - Shifts and logical ops: C = 0.
  - MUL: result = low WIDTH bits of the unsigned product; C = 1 if the high half is nonzero.
  - Any flag not named for an op is 0. Every completed op rewrites all 5 flags.
- **Undefined opcode.** `result` ← 0, flags unchanged, `op_err` and `out_valid` pulse together.
- **FSM.**
  - IDLE: `in_ready` = 1. Accepting MUL → MUL_BUSY with a shift-add counter of WIDTH.
  - MUL_BUSY: `in_ready` = 0. One partial product per cycle. When the counter reaches 0, write `result`/`flags`, pulse `out_valid` → IDLE.

## Timing
- **Reset.** `result` = 0, `flags` = 0, `out_valid` = 0, `op_err` = 0, `in_ready` = 1, state = IDLE.
  - Assertion mid-MUL abandons the product immediately; no `out_valid` is produced.
- **Single-cycle ops.** Accepted at edge k → `result`/`flags` valid and `out_valid` high in the cycle after edge k.
  - Throughput is 1 op/cycle.
  - ADDC at edge k+1 sees the C written at edge k (no hazard).
- **MUL.** Accepted at edge k → `in_ready` low from edge k until edge k+WIDTH.
  - `out_valid` is high in the cycle after edge k+WIDTH, and `in_ready` is high again in that same cycle (back-to-back accept allowed).
- **Inputs while busy.** `in_valid` with `in_ready` low is ignored; the source must hold its inputs.
- No output backpressure: `out_valid` is never stretched.

## Test plan
- Reset, then ADDU a=FFFF b=0001 (WIDTH=16) → result 0000, Z=1, C=1, `out_valid` one cycle later. Next ADDCU a=0 b=0 → result 0001, C=0.
- ADD a=7FFF b=0001 → 8000, F=1, N=1. Then immediate SUB (class 1001) with `opcode[3:0]`=F, `b[3:0]`=F (imm −1) on a=0005 → 0006.
- CMP a=FFFF b=0001 → L=0, N=1, Z=0, result 0. CMP a=0003 b=0003 → Z=1.
- ARSH a=8000 b=0004 → F800. ARSH b=0010 → FFFF. RSH b=0010 → 0000. LSH a=0001 b=000F → 8000.
- MUL a=0100 b=0100 → result 0000, C=1, Z=1.
  - `in_ready` low for exactly 16 cycles, `out_valid` on cycle 17.
  - ADD presented during busy is ignored until `in_ready` rises.
  - Repeat with `rst_n` pulsed at cycle 8 → no `out_valid`, `in_ready`=1, flags=0.
- Opcode 0x0F → `op_err` and `out_valid` pulse, result 0, flags keep prior value. Sweep WIDTH=32 on the first scenario.
